// File: rtl/mips_loader_if.sv
// Byte-source, core and memory-port signals of the mips boot loader.
// The slave modport is the loader's view; the master modport is the surroundings.
// No state; pure signal bundle.
interface mips_loader_if #(
  parameter int WIDTH = 8
);
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             cpu_memread;
  logic             cpu_memwrite;
  logic [WIDTH-1:0] cpu_adr;
  logic [WIDTH-1:0] cpu_writedata;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_writedata;

  modport slave (
    input  ld_valid, ld_data, ld_last,
    input  cpu_memread, cpu_memwrite, cpu_adr, cpu_writedata,
    output ld_ready,
    output mem_read, mem_write, mem_adr, mem_writedata
  );

  modport master (
    output ld_valid, ld_data, ld_last,
    output cpu_memread, cpu_memwrite, cpu_adr, cpu_writedata,
    input  ld_ready,
    input  mem_read, mem_write, mem_adr, mem_writedata
  );
endinterface

// File: rtl/mips_loader.sv
// Boot loader: streams an image into the shared memory port, then releases the core.
// Latency: accepted byte written in the same cycle; core released HOLD_CYCLES+1 cycles after the last byte.
// Backpressure: ld_ready is high for the whole of LOAD (one byte per cycle), low everywhere else.
module mips_loader #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  mips_loader_if.slave     bus,
  output logic             cpu_reset,
  output logic             running,
  output logic             err,
  output logic [WIDTH:0]   ld_count,
  output logic [WIDTH-1:0] checksum
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] adr_q, adr_d;
  logic [WIDTH:0]   count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             err_q, err_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic [3:0]       hold_q, hold_d;

  logic             ld_ready_c;
  logic             mem_read_c;
  logic             mem_write_c;
  logic [WIDTH-1:0] mem_adr_c;
  logic [WIDTH-1:0] mem_writedata_c;

  // Next-state, load bookkeeping and memory-port mux.
  always_comb begin
    state_d         = state_q;
    adr_d           = adr_q;
    count_d         = count_q;
    sum_d           = sum_q;
    err_d           = err_q;
    hold_d          = hold_q;
    ld_ready_c      = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    mem_adr_c       = '0;
    mem_writedata_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready_c = 1'b1;
        if (bus.ld_valid) begin
          mem_write_c     = 1'b1;
          mem_adr_c       = adr_q;
          mem_writedata_c = bus.ld_data;
          adr_d           = adr_q + 1'b1;
          count_d         = count_q + 1'b1;
          sum_d           = sum_q + bus.ld_data;
          if (bus.ld_last) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else if (adr_q == {WIDTH{1'b1}}) begin
            // Image ran past the top of memory; last byte is still kept.
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (start) begin
          state_d = ST_LOAD;
        end else if (hold_q == 4'(HOLD_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Core owns the port, including during the aborting start cycle.
        mem_read_c      = bus.cpu_memread;
        mem_write_c     = bus.cpu_memwrite;
        mem_adr_c       = bus.cpu_adr;
        mem_writedata_c = bus.cpu_writedata;
        if (start) state_d = ST_LOAD;
      end
      ST_ERR: begin
        if (start) state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every (re)load begins from a clean address, count, checksum and error flag.
    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      adr_d   = '0;
      count_d = '0;
      sum_d   = '0;
      err_d   = 1'b0;
    end

    // Registered core reset tracks the upcoming state so it toggles with RUN entry/exit.
    cpu_reset_d = (state_d != ST_RUN);
  end

  // State and load bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.ld_ready      = ld_ready_c;
  assign bus.mem_read      = mem_read_c;
  assign bus.mem_write     = mem_write_c;
  assign bus.mem_adr       = mem_adr_c;
  assign bus.mem_writedata = mem_writedata_c;

  assign cpu_reset = cpu_reset_q;
  assign running   = (state_q == ST_RUN);
  assign err       = err_q;
  assign ld_count  = count_q;
  assign checksum  = sum_q;

endmodule

// File: tb/tb_mips_loader.sv
// Testbench for mips_loader: directed vector table, corner-case sequences, random traffic.
// Expected values come from constants and an image-level reference model.
// Inputs change 1ns after the rising edge; outputs are sampled 3ns after it.
module tb_mips_loader;
  localparam int W = 8;
  localparam int H = 4;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_HOLD = 2;
  localparam int P_RUN  = 3;
  localparam int P_ERR  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         cpu_reset;
  logic         running;
  logic         err;
  logic [W:0]   ld_count;
  logic [W-1:0] checksum;

  mips_loader_if #(.WIDTH(W)) bus ();

  mips_loader #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .running   (running),
    .err       (err),
    .ld_count  (ld_count),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, bytes of the current image, remaining hold cycles.
  int         m_phase;
  logic [7:0] m_img[$];
  int         m_hold_left;

  // Values sampled by the last step.
  logic       s_w, s_rdy, s_crst, s_run;
  logic [7:0] s_a, s_d, s_sum;
  logic [8:0] s_cnt;

  typedef struct {
    logic       st, vl;
    logic [7:0] dt;
    logic       lst, cwr;
    logic [7:0] cadr, cwd;
    logic       e_w;
    logic [7:0] e_a, e_d;
    logic       e_rdy;
    logic [8:0] e_cnt;
    logic [7:0] e_sum;
    logic       e_crst, e_run;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] img_sum();
    logic [7:0] s = 8'h00;
    foreach (m_img[i]) s = s + m_img[i];
    return s;
  endfunction

  // One clock cycle: apply inputs, compare against the model, advance the model.
  task automatic step(input logic st, input logic vl, input logic [7:0] dt, input logic lst,
                      input logic crd, input logic cwr, input logic [7:0] cadr,
                      input logic [7:0] cwd, input logic rs);
    logic       e_r, e_w;
    logic [7:0] e_a, e_d;
    start             = st;
    reset             = rs;
    bus.ld_valid      = vl;
    bus.ld_data       = dt;
    bus.ld_last       = lst;
    bus.cpu_memread   = crd;
    bus.cpu_memwrite  = cwr;
    bus.cpu_adr       = cadr;
    bus.cpu_writedata = cwd;
    #2;
    e_r = 1'b0; e_w = 1'b0; e_a = 8'h00; e_d = 8'h00;
    if (m_phase == P_LOAD && vl) begin
      e_w = 1'b1;
      e_a = 8'(m_img.size());
      e_d = dt;
    end else if (m_phase == P_RUN) begin
      e_r = crd; e_w = cwr; e_a = cadr; e_d = cwd;
    end
    chk("ld_ready",      32'(bus.ld_ready),      32'(m_phase == P_LOAD));
    chk("mem_read",      32'(bus.mem_read),      32'(e_r));
    chk("mem_write",     32'(bus.mem_write),     32'(e_w));
    chk("mem_adr",       32'(bus.mem_adr),       32'(e_a));
    chk("mem_writedata", 32'(bus.mem_writedata), 32'(e_d));
    chk("running",       32'(running),           32'(m_phase == P_RUN));
    chk("cpu_reset",     32'(cpu_reset),         32'(m_phase != P_RUN));
    chk("err",           32'(err),               32'(m_phase == P_ERR));
    chk("ld_count",      32'(ld_count),          32'(m_img.size()));
    chk("checksum",      32'(checksum),          32'(img_sum()));
    s_w = bus.mem_write; s_a = bus.mem_adr; s_d = bus.mem_writedata; s_rdy = bus.ld_ready;
    s_cnt = ld_count; s_sum = checksum; s_crst = cpu_reset; s_run = running;

    if (rs) begin
      m_phase = P_IDLE;
      m_img.delete();
    end else begin
      case (m_phase)
        P_LOAD: begin
          if (vl) begin
            m_img.push_back(dt);
            if (lst) begin
              m_phase     = P_HOLD;
              m_hold_left = H;
            end else if (m_img.size() == 256) begin
              m_phase = P_ERR;
            end
          end
        end
        P_HOLD: begin
          if (st) begin
            m_phase = P_LOAD;
            m_img.delete();
          end else begin
            m_hold_left--;
            if (m_hold_left == 0) m_phase = P_RUN;
          end
        end
        default: begin
          if (st) begin
            m_phase = P_LOAD;
            m_img.delete();
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
  endtask

  initial begin
    int k;
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 9'd0, 8'h00, 1, 0};
    tbl[1]  = '{0, 0, 8'h00, 0, 1, 8'h40, 8'h5A, 0, 8'h00, 8'h00, 1, 9'd0, 8'h00, 1, 0};
    tbl[2]  = '{0, 1, 8'h20, 0, 1, 8'h40, 8'h5A, 1, 8'h00, 8'h20, 1, 9'd0, 8'h00, 1, 0};
    tbl[3]  = '{0, 1, 8'h01, 0, 1, 8'h40, 8'h5A, 1, 8'h01, 8'h01, 1, 9'd1, 8'h20, 1, 0};
    tbl[4]  = '{0, 1, 8'h02, 0, 1, 8'h40, 8'h5A, 1, 8'h02, 8'h02, 1, 9'd2, 8'h21, 1, 0};
    tbl[5]  = '{0, 1, 8'hFF, 1, 1, 8'h40, 8'h5A, 1, 8'h03, 8'hFF, 1, 9'd3, 8'h23, 1, 0};
    for (int i = 6; i < 10; i++)
      tbl[i] = '{0, 0, 8'h00, 0, 1, 8'h40, 8'h5A, 0, 8'h00, 8'h00, 0, 9'd4, 8'h22, 1, 0};
    tbl[10] = '{0, 0, 8'h00, 0, 1, 8'h40, 8'h5A, 1, 8'h40, 8'h5A, 0, 9'd4, 8'h22, 0, 1};
    tbl[11] = '{1, 0, 8'h00, 0, 1, 8'h40, 8'h5A, 1, 8'h40, 8'h5A, 0, 9'd4, 8'h22, 0, 1};
    tbl[12] = '{0, 0, 8'h00, 0, 1, 8'h40, 8'h5A, 0, 8'h00, 8'h00, 1, 9'd0, 8'h00, 1, 0};

    start = 0; reset = 1;
    bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
    bus.cpu_memread = 0; bus.cpu_memwrite = 0; bus.cpu_adr = 0; bus.cpu_writedata = 0;
    repeat (2) @(posedge clk);
    #1;
    m_phase = P_IDLE;
    m_img.delete();
    m_hold_left = 0;

    // Directed load of 0x20,0x01,0x02,0xFF, release, pass-through, abort.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].st, tbl[i].vl, tbl[i].dt, tbl[i].lst, 0, tbl[i].cwr, tbl[i].cadr, tbl[i].cwd, 0);
      chk($sformatf("vec%0d.mem_write", i),     32'(s_w),    32'(tbl[i].e_w));
      chk($sformatf("vec%0d.mem_adr", i),       32'(s_a),    32'(tbl[i].e_a));
      chk($sformatf("vec%0d.mem_writedata", i), 32'(s_d),    32'(tbl[i].e_d));
      chk($sformatf("vec%0d.ld_ready", i),      32'(s_rdy),  32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.ld_count", i),      32'(s_cnt),  32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.checksum", i),      32'(s_sum),  32'(tbl[i].e_sum));
      chk($sformatf("vec%0d.cpu_reset", i),     32'(s_crst), 32'(tbl[i].e_crst));
      chk($sformatf("vec%0d.running", i),       32'(s_run),  32'(tbl[i].e_run));
    end

    // Valid toggling every other cycle during a load; core traffic must stay blocked.
    for (int i = 0; i < 12; i++)
      step(0, 1'(i % 2), 8'($urandom), 1'(i == 11), 1, 1, 8'h40, 8'h5A, 0);
    chk("toggle.ld_count", 32'(ld_count), 32'd6);
    idle(H + 3);

    // Overflow: 256 bytes with no last marker.
    step(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 256; i++) step(0, 1, 8'(i * 7 + 3), 0, 0, 0, 8'h00, 8'h00, 0);
    chk("ovf.err",       32'(err),       32'd1);
    chk("ovf.ld_count",  32'(ld_count),  32'd256);
    chk("ovf.cpu_reset", 32'(cpu_reset), 32'd1);
    step(0, 1, 8'h11, 1, 1, 1, 8'h40, 8'h5A, 0);
    step(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    chk("reload.err",      32'(err),      32'd0);
    chk("reload.ld_count", 32'(ld_count), 32'd0);
    chk("reload.ld_ready", 32'(bus.ld_ready), 32'd1);

    // Reset after 2 of 5 bytes.
    step(0, 1, 8'hA1, 0, 0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'hA2, 0, 0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'hA3, 0, 1, 1, 8'h40, 8'h5A, 1);
    chk("rst.ld_ready",  32'(bus.ld_ready),  32'd0);
    chk("rst.ld_count",  32'(ld_count),      32'd0);
    chk("rst.cpu_reset", 32'(cpu_reset),     32'd1);
    chk("rst.mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst.mem_read",  32'(bus.mem_read),  32'd0);
    chk("rst.running",   32'(running),       32'd0);

    // Release latency measured from the last accept.
    step(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'h10, 0, 0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'h20, 1, 0, 0, 8'h00, 8'h00, 0);
    k = 1;
    while (k <= 20) begin
      step(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
      if (s_crst == 1'b0) break;
      k++;
    end
    chk("release_latency", 32'(k), 32'(H + 1));

    // Start during HOLD restarts the load.
    step(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    step(0, 1, 8'h55, 1, 0, 0, 8'h00, 8'h00, 0);
    step(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    step(1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    chk("hold_restart.ld_count", 32'(ld_count), 32'd0);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom % 50 == 0), 1'($urandom % 3 != 0), 8'($urandom), 1'($urandom % 10 == 0),
           1'($urandom % 2), 1'($urandom % 2), 8'($urandom), 8'($urandom),
           1'($urandom % 300 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
